// File: rtl/verify_sched.sv
// Round-robin frame scheduler in front of the verify sequence checker.
// Optional per-source result statistics when VERIFY_SCHED_STATS_EN is defined.
module verify_sched #(
  parameter int unsigned freq         = 200,
  parameter int unsigned UART_RX_BAUD = 20,
  parameter int unsigned MAX_LEN      = 32,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_char,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_char,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] chk_char,
  output logic       chk_valid,
  input  logic       chk_seq_valid,
  input  logic       chk_strobe,
  output logic [1:0] grant,
  output logic       res_valid,
  output logic       res_ch,
  output logic       res_ok,
  output logic [1:0] res_err
`ifdef VERIFY_SCHED_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_fail
`endif
);

  localparam int unsigned TR    = freq / UART_RX_BAUD;
  localparam int unsigned GAP_W = $clog2(TR);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, PREFIX, FETCH, DRAIN, WAIT_RES, REPORT} state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ready_q, ready_d;
  logic [7:0]        chk_char_q, chk_char_d;
  logic              chk_valid_q, chk_valid_d;
  logic              res_valid_q, res_valid_d;
  logic              res_ch_q, res_ch_d;
  logic              res_ok_q, res_ok_d;
  logic [1:0]        res_err_q, res_err_d;

  logic              acc;
  logic [7:0]        acc_char;

  // Handshake with the currently granted source
  assign acc      = grant_q[1] ? (req1_valid & ready_q[1]) : (req0_valid & ready_q[0]);
  assign acc_char = grant_q[1] ? req1_char : req0_char;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      last_q      <= 1'b1;
      grant_q     <= '0;
      ready_q     <= '0;
      chk_char_q  <= '0;
      chk_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= 1'b0;
      res_ok_q    <= 1'b0;
      res_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      len_q       <= len_d;
      tmo_q       <= tmo_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      chk_char_q  <= chk_char_d;
      chk_valid_q <= chk_valid_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_ok_q    <= res_ok_d;
      res_err_q   <= res_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gap_d       = (gap_q == '0) ? '0 : gap_q - GAP_W'(1);
    len_d       = len_q;
    tmo_d       = '0;
    last_d      = last_q;
    grant_d     = grant_q;
    ready_d     = '0;
    chk_char_d  = chk_char_q;
    chk_valid_d = 1'b0;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_ok_d    = res_ok_q;
    res_err_d   = res_err_q;

    case (state_q)
      IDLE: begin
        len_d = '0;
        // Ties go to the source that was not served last
        if (req0_valid && (!req1_valid || last_q)) begin
          grant_d = 2'b01;
          state_d = PREFIX;
        end else if (req1_valid) begin
          grant_d = 2'b10;
          state_d = PREFIX;
        end
      end
      PREFIX: begin
        if (gap_q == '0) begin
          chk_valid_d = 1'b1;
          chk_char_d  = 8'h00;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (acc) begin
          if (acc_char == 8'h00) begin
            if (len_q != '0) begin
              chk_valid_d = 1'b1;
              chk_char_d  = 8'h00;
              state_d     = WAIT_RES;
            end
          end else if (len_q == LEN_W'(MAX_LEN)) begin
            // Overlong frame: drop this character and terminate the checker's view
            chk_valid_d = 1'b1;
            chk_char_d  = 8'h00;
            state_d     = DRAIN;
          end else begin
            chk_valid_d = 1'b1;
            chk_char_d  = acc_char;
            len_d       = len_q + LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        if (acc && (acc_char == 8'h00)) begin
          state_d     = REPORT;
          res_valid_d = 1'b1;
          res_ch_d    = grant_q[1];
          res_ok_d    = 1'b0;
          res_err_d   = 2'b10;
        end
      end
      WAIT_RES: begin
        tmo_d = (tmo_q == TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
        if (chk_strobe) begin
          state_d     = REPORT;
          res_valid_d = 1'b1;
          res_ch_d    = grant_q[1];
          res_ok_d    = chk_seq_valid;
          res_err_d   = 2'b00;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          state_d     = REPORT;
          res_valid_d = 1'b1;
          res_ch_d    = grant_q[1];
          res_ok_d    = 1'b0;
          res_err_d   = 2'b01;
        end
      end
      REPORT: begin
        last_d  = grant_q[1];
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Character pacing toward the checker
    if (chk_valid_d) gap_d = GAP_W'(TR - 1);
    if (((state_d == FETCH) && (gap_d == '0)) || (state_d == DRAIN)) ready_d = grant_d;
  end

  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign chk_char   = chk_char_q;
  assign chk_valid  = chk_valid_q;
  assign grant      = grant_q;
  assign res_valid  = res_valid_q;
  assign res_ch     = res_ch_q;
  assign res_ok     = res_ok_q;
  assign res_err    = res_err_q;

`ifdef VERIFY_SCHED_STATS_EN
  logic [15:0] stat_ok_q, stat_fail_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Saturating per-source result counters, bumped as each result is issued
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_ok_q   <= '0;
      stat_fail_q <= '0;
    end else if (res_valid_d) begin
      if (res_ok_d) begin
        if (res_ch_d) stat_ok_q[15:8] <= sat_inc(stat_ok_q[15:8]);
        else          stat_ok_q[7:0]  <= sat_inc(stat_ok_q[7:0]);
      end else begin
        if (res_ch_d) stat_fail_q[15:8] <= sat_inc(stat_fail_q[15:8]);
        else          stat_fail_q[7:0]  <= sat_inc(stat_fail_q[7:0]);
      end
    end
  end

  assign stat_ok   = stat_ok_q;
  assign stat_fail = stat_fail_q;
`endif

endmodule

// File: tb/tb_verify_sched.sv
// Directed bench for verify_sched: frame table, round-robin, overflow, timeout, mid-frame reset.
module tb_verify_sched;

  localparam int MAXL = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req0_char, req1_char;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] chk_char;
  logic       chk_valid, chk_seq_valid, chk_strobe;
  logic [1:0] grant;
  logic       res_valid, res_ch, res_ok;
  logic [1:0] res_err;
`ifdef VERIFY_SCHED_STATS_EN
  logic [15:0] stat_ok, stat_fail;
`endif

  always #5 clk = ~clk;

  verify_sched dut (
    .clk(clk), .rst(rst),
    .req0_char(req0_char), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_char(req1_char), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .chk_char(chk_char), .chk_valid(chk_valid),
    .chk_seq_valid(chk_seq_valid), .chk_strobe(chk_strobe),
    .grant(grant), .res_valid(res_valid), .res_ch(res_ch), .res_ok(res_ok), .res_err(res_err)
`ifdef VERIFY_SCHED_STATS_EN
    , .stat_ok(stat_ok), .stat_fail(stat_fail)
`endif
  );

  typedef struct {
    int         src;
    logic [79:0] body;
    int         blen;
    int         lead;
    int         reps;
    bit         strobe_en;
    bit         verdict;
    int         exp_ch;
    int         exp_ok;
    int         exp_err;
    int         exp_n;
  } vec_t;

  typedef struct packed {logic ch; logic ok; logic [1:0] err;} res_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit abort = 1'b0;

  logic [7:0] chk_q[$];
  logic [7:0] exp_q[$];
  res_t       res_q[$];
  int         chk_cyc_last, res_cyc, strobe_cyc, prev_cyc, min_gap;
  logic [1:0] first_grant;
  bit         model_en, model_verdict;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe checker-side characters and results
  initial begin
    forever begin
      @(negedge clk);
      if (chk_valid) begin
        if (chk_q.size() == 0) first_grant = grant;
        else if (cyc - prev_cyc < min_gap) min_gap = cyc - prev_cyc;
        chk_q.push_back(chk_char);
        prev_cyc = cyc;
        chk_cyc_last = cyc;
      end
      if (res_valid) begin
        res_q.push_back({res_ch, res_ok, res_err});
        res_cyc = cyc;
      end
    end
  end

  // Checker model: verdict strobe three cycles after a terminator that closes a non-empty frame
  initial begin
    int pend, nchar;
    pend = 0;
    nchar = 0;
    chk_strobe = 1'b0;
    chk_seq_valid = 1'b0;
    forever begin
      @(negedge clk);
      chk_strobe = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          chk_strobe = 1'b1;
          chk_seq_valid = model_verdict;
          strobe_cyc = cyc;
        end
      end
      if (chk_valid) begin
        if (chk_char == 8'h00) begin
          if (nchar > 0 && model_en) pend = 3;
          nchar = 0;
        end else begin
          nchar++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    chk_q.delete();
    res_q.delete();
    exp_q.delete();
    min_gap = 1000000;
  endtask

  task automatic put(input int src, input logic [7:0] b);
    int n;
    if (abort) return;
    @(negedge clk);
    if (src == 0) begin req0_char = b; req0_valid = 1'b1; end
    else begin req1_char = b; req1_valid = 1'b1; end
    n = 0;
    while (!((src == 0) ? req0_ready : req1_ready)) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        total++;
        bad++;
        abort = 1'b1;
        $display("FAIL put_handshake src=%0d: ready stayed 0, required 1", src);
        return;
      end
    end
  endtask

  task automatic send_frame(input int src, input logic [79:0] body, input int blen,
                            input int lead, input int reps);
    for (int i = 0; i < lead; i++) put(src, 8'h00);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < blen; i++) put(src, body[8*(blen-1-i) +: 8]);
    put(src, 8'h00);
    @(negedge clk);
    if (src == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Expected checker stream: prefix NUL, forwarded characters, terminator (real or injected)
  task automatic build_exp(input logic [79:0] body, input int blen, input int reps);
    int cnt;
    cnt = 0;
    exp_q.push_back(8'h00);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < blen; i++)
        if (cnt < MAXL) begin
          exp_q.push_back(body[8*(blen-1-i) +: 8]);
          cnt++;
        end
    exp_q.push_back(8'h00);
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while (res_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic check_stream(input string name);
    int mism;
    mism = (chk_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < chk_q.size() && i < exp_q.size(); i++)
      if (chk_q[i] != exp_q[i]) mism++;
    check(name, mism, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 80'("(1+2)"),      5,  1, 1, 1'b1, 1'b1, 0, 1, 0, 7};
    vecs[1] = '{1, 80'("(1+2"),       4,  0, 1, 1'b1, 1'b0, 1, 0, 0, 6};
    vecs[2] = '{0, 80'("ABCDEFGHIJ"), 10, 0, 4, 1'b1, 1'b1, 0, 0, 2, 34};
    vecs[3] = '{1, 80'("[x]"),        3,  2, 1, 1'b0, 1'b1, 1, 0, 1, 5};
    vecs[4] = '{0, 80'("(A)"),        3,  0, 1, 1'b1, 1'b1, 0, 1, 0, 5};

    rst = 1'b0;
    req0_char = '0; req1_char = '0; req0_valid = 1'b0; req1_valid = 1'b0;
    model_en = 1'b1; model_verdict = 1'b1;
    clear_obs();
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({req0_ready, req1_ready, chk_valid, res_valid, res_ok, res_ch,
                                 chk_char, res_err}), 0);
    check("reset_grant", int'(grant), 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_grant", int'(grant), 0);

    for (int v = 0; v < 5; v++) begin
      clear_obs();
      model_en = vecs[v].strobe_en;
      model_verdict = vecs[v].verdict;
      build_exp(vecs[v].body, vecs[v].blen, vecs[v].reps);
      send_frame(vecs[v].src, vecs[v].body, vecs[v].blen, vecs[v].lead, vecs[v].reps);
      wait_results(1, 2000);
      check($sformatf("v%0d_res_count", v), res_q.size(), 1);
      if (res_q.size() >= 1) begin
        check($sformatf("v%0d_res_ch", v), int'(res_q[0].ch), vecs[v].exp_ch);
        check($sformatf("v%0d_res_ok", v), int'(res_q[0].ok), vecs[v].exp_ok);
        check($sformatf("v%0d_res_err", v), int'(res_q[0].err), vecs[v].exp_err);
      end
      check($sformatf("v%0d_chk_count", v), chk_q.size(), vecs[v].exp_n);
      check_stream($sformatf("v%0d_chk_stream", v));
      check($sformatf("v%0d_grant", v), int'(first_grant), 1 << vecs[v].src);
      check($sformatf("v%0d_min_gap_ge10", v), int'(min_gap >= 10), 1);
      if (vecs[v].exp_err == 1)
        check($sformatf("v%0d_timeout_latency", v), res_cyc - chk_cyc_last, 1024);
      if (vecs[v].exp_err == 0)
        check($sformatf("v%0d_strobe_latency", v), res_cyc - strobe_cyc, 1);
      check($sformatf("v%0d_grant_released", v), int'(grant), 0);
    end

    // Both sources contend from reset: source 0 wins the first tie, then strict alternation
    do_reset();
    clear_obs();
    model_en = 1'b1;
    model_verdict = 1'b1;
    for (int k = 0; k < 4; k++) build_exp((k % 2 == 0) ? 80'("(A*B)") : 80'("(C*D)"), 5, 1);
    fork
      begin
        send_frame(0, 80'("(A*B)"), 5, 0, 1);
        send_frame(0, 80'("(A*B)"), 5, 0, 1);
      end
      begin
        send_frame(1, 80'("(C*D)"), 5, 0, 1);
        send_frame(1, 80'("(C*D)"), 5, 0, 1);
      end
    join
    wait_results(4, 3000);
    check("rr_res_count", res_q.size(), 4);
    for (int k = 0; k < 4 && k < res_q.size(); k++) begin
      check($sformatf("rr%0d_res_ch", k), int'(res_q[k].ch), k % 2);
      check($sformatf("rr%0d_res_ok", k), int'(res_q[k].ok), 1);
    end
    check_stream("rr_chk_stream");
    check("rr_min_gap_ge10", int'(min_gap >= 10), 1);

    // Reset in the middle of a frame, then resend it
    clear_obs();
    put(0, 8'h28);
    put(0, 8'h31);
    put(0, 8'h2B);
    @(negedge clk);
    req0_valid = 1'b0;
    for (int k = 0; k < 200 && chk_q.size() < 4; k++) @(negedge clk);
    check("mid_pre_reset_chars", chk_q.size(), 4);
    rst = 1'b0;
    @(negedge clk);
    check("mid_chk_valid", int'(chk_valid), 0);
    check("mid_grant", int'(grant), 0);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("mid_no_result", res_q.size(), 0);
    clear_obs();
    build_exp(80'("(1+2)"), 5, 1);
    send_frame(0, 80'("(1+2)"), 5, 0, 1);
    wait_results(1, 2000);
    check("resend_res_count", res_q.size(), 1);
    if (res_q.size() >= 1) begin
      check("resend_res_ch", int'(res_q[0].ch), 0);
      check("resend_res_ok", int'(res_q[0].ok), 1);
      check("resend_res_err", int'(res_q[0].err), 0);
    end
    check_stream("resend_chk_stream");

`ifdef VERIFY_SCHED_STATS_EN
    // Only the resent frame has completed since the last reset
    check("stat_ok", int'(stat_ok), 16'h0001);
    check("stat_fail", int'(stat_fail), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
